// File: rtl/rv_pipe_buf.sv
// rv_pipe_buf: ready/valid pipeline buffer between ID and EX.
// DEPTH-entry register FIFO with synchronous flush (branch redirect),
// 1-cycle fill latency, full-rate streaming and no full-state bypass.
module rv_pipe_buf #(
    parameter int WIDTH      = 64,
    parameter int DEPTH      = 2,
    parameter bit FLUSH_ZERO = 1'b1
) (
    input  logic                       i_pb_clk,
    input  logic                       i_pb_rst,
    input  logic                       i_pb_flush,
    input  logic                       i_pb_valid,
    output logic                       o_pb_ready,
    input  logic [WIDTH-1:0]           i_pb_data,
    output logic                       o_pb_valid,
    input  logic                       i_pb_ready,
    output logic [WIDTH-1:0]           o_pb_data,
    output logic [$clog2(DEPTH+1)-1:0] o_pb_count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wptr;
    logic [PW-1:0]    rptr;
    logic [CW-1:0]    count;
    logic             push;
    logic             pop;
    logic             clear;

    // Ready looks only at occupancy and reset, never at downstream ready,
    // so a full buffer blocks upstream even when it drains this cycle.
    assign o_pb_ready = (count < CW'(DEPTH)) && !i_pb_rst;
    assign o_pb_valid = (count != '0);
    assign o_pb_data  = mem[rptr];
    assign o_pb_count = count;

    assign push  = i_pb_valid && o_pb_ready && !i_pb_flush;
    assign pop   = o_pb_valid && i_pb_ready && !i_pb_flush;
    assign clear = i_pb_rst || i_pb_flush;

    // Pointer and occupancy bookkeeping; reset/flush win over push/pop.
    // DEPTH is a power of two, so pointers wrap naturally.
    always_ff @(posedge i_pb_clk) begin
        if (clear) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= wptr + PW'(1);
            if (pop)  rptr <= rptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Entry storage; optionally scrubbed on reset/flush so the head reads 0 while empty.
    always_ff @(posedge i_pb_clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (FLUSH_ZERO && clear)
                mem[i] <= '0;
            else if (push && (wptr == PW'(i)))
                mem[i] <= i_pb_data;
        end
    end
endmodule

// File: doc/rv_pipe_buf.md
RV_PIPE_BUF -- requirements
Module: rv_pipe_buf

Interface
REQ-001 Parameter WIDTH, default 64, SHALL set the payload width in bits (legal range 1..256).
REQ-002 Parameter DEPTH, default 2, SHALL set the number of buffer entries (power of 2, legal range 2..16).
REQ-003 Parameter FLUSH_ZERO, default 1, SHALL force o_pb_data to zero after reset and after flush when 1, and leave stale payload when 0.
REQ-004 The module SHALL have a single clock; reset SHALL be synchronous and active-high.
REQ-005 i_pb_clk  input  1  SHALL be the clock; all state SHALL change only on its rising edge.
REQ-006 i_pb_rst  input  1  SHALL be the synchronous, active-high reset.
REQ-007 i_pb_flush  input  1  SHALL be the synchronous discard of all buffered entries (branch/jump redirect).
REQ-008 i_pb_valid  input  1  SHALL indicate that upstream offers i_pb_data.
REQ-009 o_pb_ready  output  1  SHALL indicate that the buffer accepts a word this cycle.
REQ-010 i_pb_data  input  WIDTH  SHALL be the upstream payload (packed ID/EX control and operand fields).
REQ-011 o_pb_valid  output  1  SHALL indicate that o_pb_data holds a valid head entry.
REQ-012 i_pb_ready  input  1  SHALL indicate downstream acceptance; when low, the downstream is stalled.
REQ-013 o_pb_data  output  WIDTH  SHALL be the head-entry payload.
REQ-014 o_pb_count  output  $clog2(DEPTH+1)  SHALL be the number of occupied entries.

Function
REQ-015 A push SHALL occur on a cycle where i_pb_valid && o_pb_ready && !i_pb_flush.
REQ-016 A pop SHALL occur on a cycle where o_pb_valid && i_pb_ready && !i_pb_flush.
REQ-017 Storage SHALL be a DEPTH-entry register array with write and read pointers of width $clog2(DEPTH), each wrapping modulo DEPTH.
REQ-018 On a push, the count SHALL increase by 1; on a pop, the count SHALL decrease by 1.
REQ-019 On a simultaneous push and pop, the count SHALL be unchanged and both pointers SHALL advance.
REQ-020 o_pb_ready SHALL equal (count < DEPTH) && !i_pb_rst, with no combinational path from i_pb_ready.
REQ-021 When full, upstream SHALL be blocked even if a pop occurs in the same cycle, giving no bypass.
REQ-022 o_pb_valid SHALL equal (count != 0).
REQ-023 o_pb_data SHALL be driven from the entry at the read pointer.
REQ-024 Latency SHALL be exactly 1 cycle: a word pushed at edge N SHALL be visible on o_pb_data with o_pb_valid=1 after edge N, when the buffer was empty.
REQ-025 Sustained throughput SHALL be 1 word/cycle when i_pb_valid=1 and i_pb_ready=1.
REQ-026 Data ordering SHALL be strict FIFO, with no loss or duplication.
REQ-027 A push when o_pb_ready=0 SHALL be ignored; the array, pointers and count SHALL be unchanged.
REQ-028 A pop when o_pb_valid=0 SHALL be ignored.
REQ-029 While i_pb_ready=0 and o_pb_valid=1, o_pb_data and o_pb_valid SHALL hold stable.
REQ-030 Flush SHALL set the count and both pointers to 0 on the next edge.
REQ-031 Flush SHALL take priority over push and pop in the same cycle; the word offered in the flush cycle SHALL be dropped.
REQ-032 If FLUSH_ZERO=1, flush SHALL also zero every array entry so that o_pb_data=0 while empty.
REQ-033 o_pb_ready SHALL be 1 in the cycle following a flush.

Reset
REQ-034 While i_pb_rst=1 at an edge, the count, pointers, o_pb_valid and o_pb_ready SHALL be 0, and o_pb_data SHALL be 0 if FLUSH_ZERO=1.
REQ-035 Reset SHALL take priority over flush, push and pop.
REQ-036 Reset asserted mid-stream SHALL discard all entries with no partial state retained.
REQ-037 In the first cycle after reset deasserts, o_pb_ready SHALL be 1 and o_pb_valid SHALL be 0.

Verification
REQ-038 Reset then single push: WIDTH=64, DEPTH=2, push 0xA5 at cycle 1 with i_pb_ready=1 -> o_pb_valid=1 and o_pb_data=0xA5 at cycle 2, and o_pb_count returns to 0 at cycle 3.
REQ-039 Fill with stall: i_pb_ready=0, push 0x1, 0x2, 0x3 -> count=2, o_pb_ready=0, 0x3 dropped; then release -> 0x1, 0x2 emitted in order and count=0.
REQ-040 Streaming: push 0..99 back-to-back with i_pb_ready=1 -> 100 outputs, in order, 1 per cycle after a 1-cycle latency.
REQ-041 Flush race: count=1, flush in the same cycle as a push of 0x7 and a pop -> count=0, o_pb_valid=0, o_pb_data=0 and 0x7 never appears.
REQ-042 Wrap: DEPTH=4, random valid/ready for 1000 cycles -> scoreboard match, and count never exceeds 4.
REQ-043 Reset mid-stream: count=3 at DEPTH=4, assert i_pb_rst for 1 cycle -> o_pb_ready=0 during reset, count=0, and o_pb_ready=1 in the next cycle.
